rx_iq_buffer: RTL and testbench
===============================

Name: rx_iq_buffer

Overview:
- Frame FIFO between the DDC decimator outputs and the STM32 bus interface.
- Captures one 4-word frame (RX1 I/Q, RX2 I/Q, 24-bit signed each) per DDC valid strobe.
- Presents the head frame first-word-fall-through to the interface's RX IQ read sequencer.
- Reports empty, fill level and a sticky overrun flag; decouples DDC output rate from STM32 read bursts.

Parameters:
- DEPTH_LOG2, 5, log2 of FIFO depth in frames (default 32 frames).
- DATA_W, 24, width of each I/Q word; storage per entry is 4*DATA_W bits.

Ports:
- clk_in  input  1  system clock, single clock domain for all logic.
- reset  input  1  asynchronous reset, active-high.
- RX1_I  input  DATA_W  DDC channel 1 in-phase, signed.
- RX1_Q  input  DATA_W  DDC channel 1 quadrature, signed.
- RX2_I  input  DATA_W  DDC channel 2 in-phase, signed.
- RX2_Q  input  DATA_W  DDC channel 2 quadrature, signed.
- rx_valid  input  1  one-cycle strobe: the four inputs form a new frame.
- rx2_en  input  1  0 = store RX2 words as zero.
- IQ_RX_READ_REQ  input  1  reader active; pops are ignored while 0.
- IQ_RX_READ_CLK  input  1  pop request, acted on at its rising edge.
- overrun_clear  input  1  one-cycle strobe that clears overrun.
- OUT_RX1_I  output  DATA_W  head frame channel 1 I.
- OUT_RX1_Q  output  DATA_W  head frame channel 1 Q.
- OUT_RX2_I  output  DATA_W  head frame channel 2 I.
- OUT_RX2_Q  output  DATA_W  head frame channel 2 Q.
- in_empty  output  1  1 = no frame held.
- fill_level  output  DEPTH_LOG2+1  frames currently held, 0..2^DEPTH_LOG2.
- overrun  output  1  sticky: a frame was lost because the FIFO was full.

Behaviour:
- Reset (async assert, release synchronous to clk_in). On reset:
  - pointers = 0, fill_level = 0, in_empty = 1, overrun = 0.
  - all OUT_* = 0.
  - the READ_CLK edge register is set to 0.
- Pop event:
  - Defined as IQ_RX_READ_CLK = 1, its previous-cycle registered value = 0, and IQ_RX_READ_REQ = 1.
  - A level held high produces exactly one pop.
- Push event: rx_valid = 1. The stored entry is {RX1_I, RX1_Q, rx2_en ? RX2_I : 0, rx2_en ? RX2_Q : 0}, sampled that cycle.
- Head presentation (FWFT, registered outputs):
  - Push at cycle N into an empty FIFO: OUT_* carry the frame and in_empty = 0 from N+1.
  - Pop at cycle N with at least 2 frames held: OUT_* show the next frame at N+1.
  - Pop of the last frame at cycle N: in_empty = 1 at N+1 and OUT_* hold their last value.
- The reader samples OUT_* in the same cycle it raises READ_CLK; the popped frame is therefore the one it captured.
- fill_level and in_empty update at N+1 after any push or pop.
- Simultaneous push and pop, non-empty and not full: fill_level is unchanged and both operations take effect.
- Simultaneous push and pop when empty: the pop is ignored, the push is accepted, fill_level becomes 1.
- Simultaneous push and pop when full: both are accepted, fill stays at max and overrun is not set.
- Push when full with no pop: default policy drops the new frame and sets overrun = 1 at N+1.
- Pop when empty: ignored, no pointer movement, no flag.
- overrun clears on overrun_clear. If a clear and a new overrun event occur in the same cycle, overrun is set (set wins).
- Pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
  - Full: MSBs differ and the remaining bits are equal.
  - Empty: pointers are equal.
- Storage is inferred RAM with synchronous read; the head register is refilled from the RAM read port.
- IQ_RX_READ_REQ dropping to 0 mid-burst only blocks further pops; the frame contents are unaffected.
- Reset asserted mid-burst discards all content immediately.

Optional Feature:
- Macro: RX_IQ_DROP_OLDEST_EN.
- When defined, a push to a full FIFO with no pop overwrites the oldest frame:
  - both pointers advance and fill stays at max;
  - the head presents the new oldest frame at N+1;
  - overrun is set.
- When not defined, the default drop-newest behaviour above applies.

Test Plan:
- Reset, then one push with RX1_I=0x000123, RX1_Q=0xFFFFFE, RX2_I=0x7FFFFF, RX2_Q=0x800000, rx2_en=1 -> one cycle later in_empty=0, fill_level=1, OUT_* equal those inputs.
- Push 3 frames with RX1_I = 1, 2, 3, then READ_CLK pulses with READ_REQ=1 -> OUT_RX1_I steps 1, 2, 3; in_empty=1 after the third pop; fill_level ends at 0.
- READ_CLK held high 5 cycles -> exactly one pop. READ_CLK pulse with READ_REQ=0 -> no pop.
- Fill 32 frames (RX1_I = 0..31), then push RX1_I=99 -> overrun=1, fill_level=32, then pops yield 0..31. With RX_IQ_DROP_OLDEST_EN: pops yield 1..31, 99.
- Push and pop in the same cycle at fill_level=0, 5 and 32 -> fill_level becomes 1, stays 5, stays 32; overrun remains 0.
- rx2_en=0 push with RX2_I=0x123456 -> OUT_RX2_I=0. Assert overrun_clear while a full-push happens in the same cycle -> overrun stays 1. Assert reset with fill_level=10 -> fill_level=0 and in_empty=1 immediately.

Source files
------------

// File: rtl/rx_iq_buffer.sv
// Frame FIFO (4 x DATA_W I/Q words per entry) between the DDC outputs and the STM32 reader, FWFT head.
// Optional macro RX_IQ_DROP_OLDEST_EN: a push into a full FIFO overwrites the oldest frame instead of dropping the new one.
module rx_iq_buffer #(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned DATA_W     = 24
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     RX1_I,
    input  logic [DATA_W-1:0]     RX1_Q,
    input  logic [DATA_W-1:0]     RX2_I,
    input  logic [DATA_W-1:0]     RX2_Q,
    input  logic                  rx_valid,
    input  logic                  rx2_en,
    input  logic                  IQ_RX_READ_REQ,
    input  logic                  IQ_RX_READ_CLK,
    input  logic                  overrun_clear,
    output logic [DATA_W-1:0]     OUT_RX1_I,
    output logic [DATA_W-1:0]     OUT_RX1_Q,
    output logic [DATA_W-1:0]     OUT_RX2_I,
    output logic [DATA_W-1:0]     OUT_RX2_Q,
    output logic                  in_empty,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overrun
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned EW    = 4 * DATA_W;

    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     head_q;
    logic [EW-1:0]     wdata;
    logic [DATA_W-1:0] rx2_i_m, rx2_q_m;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
    logic              rclk_q, rclk_d, overrun_q, overrun_d;
    logic              empty, full, pop_ev, pop_ok, push_ok, drop_evt, rd_adv;
    logic              ld_byp, ld_ram;

    always_comb begin
        rx2_i_m  = rx2_en ? RX2_I : '0;
        rx2_q_m  = rx2_en ? RX2_Q : '0;
        wdata    = {RX1_I, RX1_Q, rx2_i_m, rx2_q_m};
        fill     = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}});
        pop_ev   = IQ_RX_READ_CLK & ~rclk_q & IQ_RX_READ_REQ;
        pop_ok   = pop_ev & ~empty;
        drop_evt = rx_valid & full & ~pop_ok;
`ifdef RX_IQ_DROP_OLDEST_EN
        push_ok  = rx_valid;
        rd_adv   = pop_ok | drop_evt;
`else
        push_ok  = rx_valid & ~drop_evt;
        rd_adv   = pop_ok;
`endif
        // New frame becomes head directly when nothing else will be left to present.
        ld_byp   = push_ok & (empty | (pop_ok & (fill == PW'(1))));
        ld_ram   = rd_adv & ~ld_byp & (fill >= PW'(2));

        wr_ptr_d = wr_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q;
        if (rd_adv) rd_ptr_d = rd_ptr_q + PW'(1);

        rclk_d    = IQ_RX_READ_CLK;
        overrun_d = overrun_q;
        if (overrun_clear) overrun_d = 1'b0;
        if (drop_evt)      overrun_d = 1'b1;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rclk_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rclk_q    <= rclk_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
    end

    // Head is the RAM's registered read port, with a bypass path for frames arriving at an empty head.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            head_q <= '0;
        end else if (ld_byp) begin
            head_q <= wdata;
        end else if (ld_ram) begin
            head_q <= mem[rd_ptr_d[DEPTH_LOG2-1:0]];
        end
    end

    assign OUT_RX1_I  = head_q[EW-1          -: DATA_W];
    assign OUT_RX1_Q  = head_q[EW-1-DATA_W   -: DATA_W];
    assign OUT_RX2_I  = head_q[EW-1-2*DATA_W -: DATA_W];
    assign OUT_RX2_Q  = head_q[DATA_W-1:0];
    assign in_empty   = empty;
    assign fill_level = fill;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_rx_iq_buffer.sv
// Directed self-checking bench for rx_iq_buffer (default parameters).
module tb_rx_iq_buffer;

    localparam int unsigned DW = 24;
    localparam int unsigned DL = 5;

    logic          clk_in = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] RX1_I = '0, RX1_Q = '0, RX2_I = '0, RX2_Q = '0;
    logic          rx_valid = 1'b0, rx2_en = 1'b1;
    logic          IQ_RX_READ_REQ = 1'b0, IQ_RX_READ_CLK = 1'b0, overrun_clear = 1'b0;
    logic [DW-1:0] OUT_RX1_I, OUT_RX1_Q, OUT_RX2_I, OUT_RX2_Q;
    logic          in_empty, overrun;
    logic [DL:0]   fill_level;

    int n_checks = 0;
    int n_fail   = 0;

    rx_iq_buffer #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
        .clk_in(clk_in), .reset(reset),
        .RX1_I(RX1_I), .RX1_Q(RX1_Q), .RX2_I(RX2_I), .RX2_Q(RX2_Q),
        .rx_valid(rx_valid), .rx2_en(rx2_en),
        .IQ_RX_READ_REQ(IQ_RX_READ_REQ), .IQ_RX_READ_CLK(IQ_RX_READ_CLK),
        .overrun_clear(overrun_clear),
        .OUT_RX1_I(OUT_RX1_I), .OUT_RX1_Q(OUT_RX1_Q),
        .OUT_RX2_I(OUT_RX2_I), .OUT_RX2_Q(OUT_RX2_Q),
        .in_empty(in_empty), .fill_level(fill_level), .overrun(overrun)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] i1, input logic [DW-1:0] q1,
                        input logic [DW-1:0] i2, input logic [DW-1:0] q2, input logic en);
        RX1_I = i1; RX1_Q = q1; RX2_I = i2; RX2_Q = q2; rx2_en = en;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic pop();
        IQ_RX_READ_REQ = 1'b1;
        IQ_RX_READ_CLK = 1'b1;
        step();
        IQ_RX_READ_CLK = 1'b0;
        step();
    endtask

    task automatic push_pop(input logic [DW-1:0] i1);
        RX1_I = i1; RX1_Q = '0; RX2_I = '0; RX2_Q = '0; rx2_en = 1'b1;
        rx_valid = 1'b1;
        IQ_RX_READ_REQ = 1'b1;
        IQ_RX_READ_CLK = 1'b1;
        step();
        rx_valid = 1'b0;
        IQ_RX_READ_CLK = 1'b0;
        step();
    endtask

    function automatic logic [31:0] exp_drain(input int k);
`ifdef RX_IQ_DROP_OLDEST_EN
        if (k < 30) return 32'(k + 2);
        return (k == 30) ? 32'd99 : 32'd77;
`else
        return (k < 31) ? 32'(k + 1) : 32'd77;
`endif
    endfunction

    initial begin
        #1 reset = 1'b1;
        #10;
        check("rst_empty", 32'(in_empty), 32'd1);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_out", 32'(OUT_RX1_I | OUT_RX1_Q | OUT_RX2_I | OUT_RX2_Q), 32'd0);
        step();
        reset = 1'b0;
        step();

        push(24'h000123, 24'hFFFFFE, 24'h7FFFFF, 24'h800000, 1'b1);
        check("p1_empty", 32'(in_empty), 32'd0);
        check("p1_fill", 32'(fill_level), 32'd1);
        check("p1_rx1i", 32'(OUT_RX1_I), 32'h000123);
        check("p1_rx1q", 32'(OUT_RX1_Q), 32'hFFFFFE);
        check("p1_rx2i", 32'(OUT_RX2_I), 32'h7FFFFF);
        check("p1_rx2q", 32'(OUT_RX2_Q), 32'h800000);
        pop();
        check("p1_pop_empty", 32'(in_empty), 32'd1);
        check("p1_pop_hold", 32'(OUT_RX1_I), 32'h000123);

        for (int i = 1; i <= 3; i++) push(DW'(i), '0, '0, '0, 1'b1);
        check("seq_fill3", 32'(fill_level), 32'd3);
        check("seq_head1", 32'(OUT_RX1_I), 32'd1);
        pop();
        check("seq_head2", 32'(OUT_RX1_I), 32'd2);
        pop();
        check("seq_head3", 32'(OUT_RX1_I), 32'd3);
        check("seq_notempty", 32'(in_empty), 32'd0);
        pop();
        check("seq_empty", 32'(in_empty), 32'd1);
        check("seq_fill0", 32'(fill_level), 32'd0);
        check("seq_hold3", 32'(OUT_RX1_I), 32'd3);

        push(24'd10, '0, '0, '0, 1'b1);
        push(24'd11, '0, '0, '0, 1'b1);
        IQ_RX_READ_REQ = 1'b1;
        IQ_RX_READ_CLK = 1'b1;
        repeat (5) step();
        IQ_RX_READ_CLK = 1'b0;
        step();
        check("held_fill", 32'(fill_level), 32'd1);
        check("held_head", 32'(OUT_RX1_I), 32'd11);
        IQ_RX_READ_REQ = 1'b0;
        IQ_RX_READ_CLK = 1'b1;
        step();
        IQ_RX_READ_CLK = 1'b0;
        step();
        check("noreq_fill", 32'(fill_level), 32'd1);
        check("noreq_head", 32'(OUT_RX1_I), 32'd11);
        pop();
        check("drain_fill", 32'(fill_level), 32'd0);

        push_pop(24'd5);
        check("pp0_fill", 32'(fill_level), 32'd1);
        check("pp0_head", 32'(OUT_RX1_I), 32'd5);
        for (int i = 6; i <= 9; i++) push(DW'(i), '0, '0, '0, 1'b1);
        check("pp5_pre", 32'(fill_level), 32'd5);
        push_pop(24'd10);
        check("pp5_fill", 32'(fill_level), 32'd5);
        check("pp5_head", 32'(OUT_RX1_I), 32'd6);
        check("pp5_ovr", 32'(overrun), 32'd0);

        for (int i = 11; i <= 15; i++) push(DW'(i), '0, '0, '0, 1'b1);
        check("rst10_pre", 32'(fill_level), 32'd10);
        #2 reset = 1'b1;
        #1;
        check("rst10_fill", 32'(fill_level), 32'd0);
        check("rst10_empty", 32'(in_empty), 32'd1);
        check("rst10_out", 32'(OUT_RX1_I), 32'd0);
        step();
        reset = 1'b0;
        step();

        push(24'h000042, 24'h000043, 24'h123456, 24'h654321, 1'b0);
        check("rx2off_i", 32'(OUT_RX2_I), 32'd0);
        check("rx2off_q", 32'(OUT_RX2_Q), 32'd0);
        check("rx2off_rx1i", 32'(OUT_RX1_I), 32'h000042);
        check("rx2off_rx1q", 32'(OUT_RX1_Q), 32'h000043);
        pop();

        for (int i = 0; i < 32; i++) push(DW'(i), '0, '0, '0, 1'b1);
        check("full_fill", 32'(fill_level), 32'd32);
        check("full_ovr0", 32'(overrun), 32'd0);
        overrun_clear = 1'b1;
        push(24'd99, '0, '0, '0, 1'b1);
        overrun_clear = 1'b0;
        check("ovr_setwins", 32'(overrun), 32'd1);
        check("ovr_fill", 32'(fill_level), 32'd32);
`ifdef RX_IQ_DROP_OLDEST_EN
        check("ovr_head", 32'(OUT_RX1_I), 32'd1);
`else
        check("ovr_head", 32'(OUT_RX1_I), 32'd0);
`endif
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);
        push_pop(24'd77);
        check("ppfull_fill", 32'(fill_level), 32'd32);
        check("ppfull_ovr", 32'(overrun), 32'd0);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("drain%0d", k), 32'(OUT_RX1_I), exp_drain(k));
            pop();
        end
        check("drain_empty", 32'(in_empty), 32'd1);
        check("drain_fill0", 32'(fill_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
